async_fifo_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the asynchronous FIFO in the read clock domain. It pops show-ahead words from the FIFO (`rdata` valid whenever `rempty` is low, `ren` pops) into a 2-entry output buffer and presents them on a valid/ready stream. It sustains one word per cycle with no combinational path from `m_ready` to `fifo_ren`. It also keeps a wrapping count of completed output transfers.

---
 rtl/async_fifo_rd_stream.sv | 99 +++++++++
 tb/tb_async_fifo_rd_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for a show-ahead asynchronous FIFO. Pops words into a
// 2-entry output buffer and presents them on a valid/ready stream. The pop
// decision never looks at m_ready, so there is no combinational path from
// the sink back to the FIFO. A wrapping counter tracks completed transfers.
module async_fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_ren,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    logic [1:0]            count_q, count_d;
    logic                  run_q, run_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  pop;
    logic                  take;

    // Pop/take qualifiers: pop uses only registered state plus FIFO/flush inputs
    always_comb begin
        pop  = run_q && !flush && !fifo_rempty && (count_q < 2'd2);
        take = (count_q != 2'd0) && m_ready;
    end

    // Next-state for the buffer, occupancy, run flag and transfer counter
    always_comb begin
        count_d    = count_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        beat_cnt_d = beat_cnt_q;
        run_d      = 1'b1;

        unique case ({pop, take})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = fifo_rdata;
                end else begin
                    buf1_d = fifo_rdata;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            // pop implies count < 2 and take implies count != 0, so count is 1:
            // the incoming word replaces the departing head directly.
            2'b11: begin
                buf0_d = fifo_rdata;
            end
            default: begin
            end
        endcase

        if (take) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        if (flush) begin
            count_d = 2'd0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            run_q      <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            run_q      <= run_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output drive: everything except fifo_ren comes straight from flops
    always_comb begin
        fifo_ren = pop;
        m_valid  = (count_q != 2'd0);
        m_data   = buf0_q;
        beat_cnt = beat_cnt_q;
    end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Self-checking bench for async_fifo_rd_stream: a queue-based model of the
// output buffer is compared against the DUT every cycle, plus literal checks
// for the directed scenarios. A second instance with a 4-bit counter covers wrap.
module tb_async_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rempty = 1'b1;
    logic       flush = 1'b0;
    logic       m_ready = 1'b0;
    logic       fifo_ren, m_valid;
    logic [7:0] m_data;
    logic [15:0] beat_cnt;
    logic       fifo_ren4, m_valid4;
    logic [7:0] m_data4;
    logic [3:0] beat_cnt4;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // environment and model state
    logic [7:0]  src[$];
    logic [7:0]  mq[$];
    logic [7:0]  got[$];
    logic        gap = 1'b0;
    logic        m_run = 1'b0;
    int unsigned m_beats = 0;
    int unsigned pops_seen = 0;
    int unsigned ren_streak = 0;
    int unsigned ren_max = 0;
    int unsigned idle_cycles = 0;

    always #5 clk = ~clk;

    async_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .fifo_rdata(fifo_rdata),
        .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .beat_cnt(beat_cnt)
    );

    async_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .fifo_rdata(fifo_rdata),
        .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren4), .flush(flush),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .beat_cnt(beat_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 1'b0;
        m_beats = 0;
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic step();
        logic exp_pop, exp_take, ren_s;
        fifo_rempty = (src.size() == 0) || gap;
        fifo_rdata  = (src.size() != 0) ? src[0] : 8'h00;
        #1;
        exp_pop  = reset_n && m_run && !flush && !fifo_rempty && (mq.size() < 2);
        exp_take = (mq.size() != 0) && m_ready;
        chk("fifo_ren", fifo_ren, exp_pop);
        chk("m_valid", m_valid, mq.size() != 0);
        if (mq.size() != 0) chk("m_data", m_data, mq[0]);
        if (!reset_n) chk("rst_m_data", m_data, 8'h00);
        chk("beat_cnt", beat_cnt, m_beats % 65536);
        chk("beat_cnt4", beat_cnt4, m_beats % 16);

        if (fifo_ren) begin
            pops_seen++;
            ren_streak++;
            if (ren_streak > ren_max) ren_max = ren_streak;
        end else begin
            ren_streak = 0;
        end
        if (m_run && !m_valid) idle_cycles++;
        if (m_valid && m_ready) got.push_back(m_data);

        if (!reset_n) begin
            model_reset();
        end else begin
            if (exp_take) begin
                void'(mq.pop_front());
                m_beats++;
            end
            if (exp_pop) mq.push_back(fifo_rdata);
            if (flush) mq.delete();
            m_run = 1'b1;
        end

        ren_s = fifo_ren;
        @(posedge clk);
        if (ren_s && src.size() != 0) void'(src.pop_front());
        @(negedge clk);
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [7:0] exp_b;
        int unsigned b0, bound;

        // reset held with a non-empty FIFO
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        model_reset();
        @(negedge clk);
        steps(3);
        chk("rst_fifo_ren", fifo_ren, 1'b0);
        chk("rst_beat_cnt", beat_cnt, 16'd0);

        // release: no pop in release cycle, first pop in the next one
        reset_n = 1'b1;
        m_ready = 1'b1;
        pops_seen = 0;
        got.delete();
        step();
        chk("release_no_pop", pops_seen, 0);
        step();
        chk("second_cycle_pop", pops_seen, 1);
        steps(20);
        chk("stream_ren_streak", ren_max, 16);
        chk("stream_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("stream_data", got[i], 8'(i + 1));
        chk("stream_beat_cnt", beat_cnt, 16'd16);
        chk("wrap_zero", beat_cnt4, 4'd0);

        // 17th transfer wraps the 4-bit counter to 1
        src.push_back(8'h33);
        steps(4);
        chk("wrap_one", beat_cnt4, 4'd1);
        chk("beat_17", beat_cnt, 16'd17);

        // backpressure: only two pops, head stable
        m_ready = 1'b0;
        pops_seen = 0;
        got.delete();
        for (int i = 0; i < 5; i++) src.push_back(8'hA0 + 8'(i));
        steps(8);
        chk("bp_pops", pops_seen, 2);
        chk("bp_valid", m_valid, 1'b1);
        chk("bp_head", m_data, 8'hA0);
        m_ready = 1'b1;
        steps(10);
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_data", got[i], 8'hA0 + 8'(i));

        // empty gaps: rempty toggles every cycle
        got.delete();
        idle_cycles = 0;
        for (int i = 0; i < 8; i++) src.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 24; i++) begin
            gap = i[0];
            step();
        end
        gap = 1'b0;
        chk("gap_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("gap_data", got[i], 8'hC0 + 8'(i));
        chk("gap_idle_seen", idle_cycles > 4, 1'b1);

        // flush with two buffered words, sink ready
        got.delete();
        m_ready = 1'b0;
        src.push_back(8'h11);
        src.push_back(8'h22);
        src.push_back(8'h44);
        bound = 0;
        while (mq.size() != 2 && bound < 10) begin
            step();
            bound++;
        end
        chk("flush_fill_timeout", bound < 10, 1'b1);
        b0 = beat_cnt;
        m_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_mvalid_next", m_valid, 1'b0);
        chk("flush_beat", beat_cnt, 16'(b0 + 1));
        steps(4);
        chk("flush_got_n", got.size(), 2);
        if (got.size() == 2) begin
            chk("flush_take", got[0], 8'h11);
            chk("flush_next", got[1], 8'h44);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (src.size() < 6 && $urandom_range(0, 2) != 0) src.push_back(8'($urandom));
            gap = ($urandom_range(0, 4) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0;
        gap = 1'b0;

        // asynchronous reset mid-stream
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) src.push_back(8'h50 + 8'(i));
        steps(3);
        chk("pre_reset_valid", m_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 1'b0);
        chk("async_rst_data", m_data, 8'h00);
        chk("async_rst_beat", beat_cnt, 16'd0);
        chk("async_rst_ren", fifo_ren, 1'b0);
        model_reset();
        @(negedge clk);
        steps(2);
        reset_n = 1'b1;
        got.delete();
        steps(8);
        chk("post_reset_beats", beat_cnt, 16'(got.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
